pp_pipeline_accel_stream_rr_arbiter: RTL

- Shares one downstream ap_fifo-style stream (full_n/write/din) between NUM_REQ upstream FIFOs (empty_n/read/dout), such as the fifo_w11 shift-register FIFOs.
- Round-robin grant with burst lock: a granted source keeps the grant for up to BURST_LEN beats or until it runs empty.
- One registered output stage. Sits between parallel pp_pipeline stages and a single consumer stream.

---
 rtl/pp_arb_pkg.sv | 25 ++
 rtl/pp_stream_out_reg.sv | 31 +++
 rtl/pp_pipeline_accel_stream_rr_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/pp_arb_pkg.sv
// pp_arb_pkg: shared state type, statistics width and round-robin search helper
// for the pp stream arbiters.
package pp_arb_pkg;
    localparam int STAT_W = 32;
    localparam int MAX_REQ = 8;
    typedef enum logic {IDLE, GRANT} state_t;
    typedef struct packed {
        logic found;
        logic [2:0] idx;
    } pick_t;
    // Scanning from the far end lets the requester nearest to last+1 overwrite the rest.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req, input int last, input int n);
        pick_t p;
        int k;
        p = '0;
        for (int i = MAX_REQ; i >= 1; i--) begin
            k = (last + i) % n;
            if (i <= n && req[k[2:0]]) begin
                p.found = 1'b1;
                p.idx = k[2:0];
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/pp_stream_out_reg.sv
// pp_stream_out_reg: single registered stream stage that holds its beat while the consumer is full.
module pp_stream_out_reg #(
    parameter int DATA_WIDTH = 11,
    parameter int SRC_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [SRC_W-1:0]      load_src,
    input  logic                  full_n,
    output logic                  can_load,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [SRC_W-1:0]      src
);
    assign can_load = !valid || full_n;
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data <= '0;
            src <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data <= load_data;
            src <= load_src;
        end else if (can_load) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/pp_pipeline_accel_stream_rr_arbiter.sv
// pp_pipeline_accel_stream_rr_arbiter: round-robin, burst-locked merge of NUM_REQ ap_fifo sources
// into one registered stream. Defining PP_ARB_STATS_EN adds per-source beat and stall counters.
module pp_pipeline_accel_stream_rr_arbiter
    import pp_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_WIDTH = 11,
    parameter int BURST_LEN = 16,
    parameter int SRC_W = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            in_empty_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_dout,
    output logic [NUM_REQ-1:0]            in_read,
    input  logic                          out_full_n,
    output logic                          out_write,
    output logic [DATA_WIDTH-1:0]         out_din,
    output logic [SRC_W-1:0]              out_src,
    output logic                          busy
`ifdef PP_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]     beat_count,
    output logic [STAT_W-1:0]             stall_count
`endif
);
    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    state_t state;
    logic [SRC_W-1:0] grant_q, last_grant;
    logic [CNT_W-1:0] beat_cnt;
    logic can_load, pop, src_avail;
    logic [DATA_WIDTH-1:0] lanes [NUM_REQ];
    pick_t pick;
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        assign lanes[k] = in_dout[k*DATA_WIDTH +: DATA_WIDTH];
    end
    assign pick = rr_pick(8'(in_empty_n), int'(last_grant), NUM_REQ);
    assign src_avail = in_empty_n[grant_q];
    assign pop = (state == GRANT) && src_avail && can_load;
    assign in_read = pop ? NUM_REQ'(1) << grant_q : '0;
    assign busy = state == GRANT;
    // Release happens on the burst's last pop or as soon as the granted source runs dry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant_q <= '0;
            last_grant <= SRC_W'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick.found) begin
                grant_q <= SRC_W'(pick.idx);
                beat_cnt <= '0;
                state <= GRANT;
            end
        end else begin
            if (pop)
                beat_cnt <= beat_cnt + 1'b1;
            if (!src_avail || (pop && beat_cnt == CNT_W'(BURST_LEN - 1))) begin
                state <= IDLE;
                last_grant <= grant_q;
            end
        end
    end
    pp_stream_out_reg #(.DATA_WIDTH(DATA_WIDTH), .SRC_W(SRC_W)) out_reg (
        .clk(clk),
        .reset(reset),
        .load(pop),
        .load_data(lanes[grant_q]),
        .load_src(grant_q),
        .full_n(out_full_n),
        .can_load(can_load),
        .valid(out_write),
        .data(out_din),
        .src(out_src)
    );
`ifdef PP_ARB_STATS_EN
    logic [STAT_W-1:0] beats [NUM_REQ];
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++)
            beats[i] <= reset ? '0 : beats[i] + STAT_W'(in_read[i]);
        stall_count <= reset ? '0 : stall_count + STAT_W'(out_write && !out_full_n);
    end
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat
        assign beat_count[k*STAT_W +: STAT_W] = beats[k];
    end
`endif
endmodule
